// File: rtl/booth_pp_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// booth_pp_accumulator_pkg
// Shared definitions for the radix-4 Booth digit stream:
//   - default operand width
//   - bit positions of an encoded digit {neg, one, two} when packed in a vector
//   - accumulator FSM state enumeration
// -----------------------------------------------------------------------------
package booth_pp_accumulator_pkg;

    localparam int N_DEFAULT = 8;

    // Packed digit layout: [DIG_NEG_POS] sign, [DIG_ONE_POS] |d|=1, [DIG_TWO_POS] |d|=2
    localparam int DIG_W       = 3;
    localparam int DIG_TWO_POS = 0;
    localparam int DIG_ONE_POS = 1;
    localparam int DIG_NEG_POS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/booth_digit_decode.sv
// -----------------------------------------------------------------------------
// booth_digit_decode
// Combinational decode of one radix-4 Booth digit into a 2N-bit signed
// partial product in {0, +md, -md, +2md, -2md}.
// Ports:
//   md      in  N    signed multiplicand
//   neg     in  1    digit sign (1 = negative)
//   one     in  1    digit magnitude 1
//   two     in  1    digit magnitude 2
//   term    out 2N   signed partial product (unshifted)
//   illegal out 1    one and two both set; term forced to 0
// -----------------------------------------------------------------------------
module booth_digit_decode #(
    parameter int N = 8
) (
    input  logic [N-1:0]   md,
    input  logic           neg,
    input  logic           one,
    input  logic           two,
    output logic [2*N-1:0] term,
    output logic           illegal
);

    logic [2*N-1:0] md_ext_s;
    logic [2*N-1:0] mag_s;

    // Magnitude select and sign application; 2N bits hold +/-2*md without overflow.
    always_comb begin
        md_ext_s = {{N{md[N-1]}}, md};
        mag_s    = '0;
        illegal  = one & two;
        if (one && two) begin
            mag_s = '0;
        end else if (two) begin
            mag_s = md_ext_s << 1;
        end else if (one) begin
            mag_s = md_ext_s;
        end else begin
            mag_s = '0;
        end
        // Negating zero yields zero, so a negative zero digit adds nothing.
        if (neg) begin
            term = '0 - mag_s;
        end else begin
            term = mag_s;
        end
    end

endmodule

// File: rtl/booth_pp_accumulator.sv
// -----------------------------------------------------------------------------
// booth_pp_accumulator
// Accepts N/2 radix-4 Booth digits LSB-first and accumulates the product of a
// captured signed multiplicand into a 2N-bit two's-complement result.
// Ports:
//   clk         in   1    clock, rising edge
//   reset       in   1    asynchronous active-high reset
//   start       in   1    begin a new multiplication (honoured in IDLE/DONE)
//   md          in   N    signed multiplicand, captured on accepted start
//   dig_valid   in   1    encoded digit present
//   dig_neg     in   1    digit sign
//   dig_one     in   1    digit magnitude 1
//   dig_two     in   1    digit magnitude 2
//   dig_ready   out  1    digit accepted this cycle when valid (ACCUM)
//   busy        out  1    operation in progress (ACCUM)
//   prod        out  2N   final product, updated only on completion
//   prod_valid  out  1    one-cycle strobe when prod is new
//   err         out  1    sticky illegal-digit flag, cleared by start
// -----------------------------------------------------------------------------
module booth_pp_accumulator
    import booth_pp_accumulator_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   md,
    input  logic           dig_valid,
    input  logic           dig_neg,
    input  logic           dig_one,
    input  logic           dig_two,
    output logic           dig_ready,
    output logic           busy,
    output logic [2*N-1:0] prod,
    output logic           prod_valid,
    output logic           err
);

    localparam int              KW     = $clog2(N / 2) + 1;
    localparam logic [KW-1:0]   K_LAST = KW'(N / 2 - 1);
    localparam logic [KW-1:0]   K_ONE  = KW'(1);

    state_t         state_r;
    state_t         state_nx_s;
    logic [N-1:0]   md_r;
    logic [2*N-1:0] acc_r;
    logic [KW-1:0]  k_r;
    logic [2*N-1:0] prod_r;
    logic           prod_valid_r;
    logic           err_r;
    logic           busy_r;

    logic [DIG_W-1:0] dig_s;
    logic [2*N-1:0]   term_s;
    logic             illegal_s;
    logic [2*N-1:0]   shifted_s;
    logic [2*N-1:0]   acc_nx_s;
    logic             start_ok_s;
    logic             transfer_s;
    logic             last_s;

    // Pack the digit strobes into the shared digit layout.
    always_comb begin
        dig_s              = '0;
        dig_s[DIG_NEG_POS] = dig_neg;
        dig_s[DIG_ONE_POS] = dig_one;
        dig_s[DIG_TWO_POS] = dig_two;
    end

    booth_digit_decode #(.N(N)) u_decode (
        .md      (md_r),
        .neg     (dig_s[DIG_NEG_POS]),
        .one     (dig_s[DIG_ONE_POS]),
        .two     (dig_s[DIG_TWO_POS]),
        .term    (term_s),
        .illegal (illegal_s)
    );

    // Handshake qualifiers and the weighted accumulation for the current digit.
    always_comb begin
        start_ok_s = start && (state_r != ST_ACCUM);
        transfer_s = dig_valid && (state_r == ST_ACCUM);
        last_s     = transfer_s && (k_r == K_LAST);
        // Digit k carries weight 4^k, i.e. a left shift by 2k.
        shifted_s  = term_s << {k_r, 1'b0};
        acc_nx_s   = acc_r + shifted_s;
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_ACCUM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_ACCUM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy flag tracking ACCUM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_ACCUM);
        end
    end

    // Operand capture, accumulator, digit counter, result and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_r         <= '0;
            acc_r        <= '0;
            k_r          <= '0;
            prod_r       <= '0;
            prod_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (start_ok_s) begin
                md_r  <= md;
                acc_r <= '0;
                k_r   <= '0;
                err_r <= 1'b0;
            end else if (transfer_s) begin
                acc_r <= acc_nx_s;
                if (last_s) begin
                    k_r <= '0;
                end else begin
                    k_r <= k_r + K_ONE;
                end
                // Illegal digits still advance k; they only raise the flag.
                if (illegal_s) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end else begin
                acc_r <= acc_r;
            end
            // prod only ever takes the completed sum, never a partial one.
            prod_valid_r <= last_s;
            if (last_s) begin
                prod_r <= acc_nx_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    assign dig_ready  = busy_r;
    assign busy       = busy_r;
    assign prod       = prod_r;
    assign prod_valid = prod_valid_r;
    assign err        = err_r;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;

    localparam int N = 8;
    localparam int W = 2 * N;
    localparam int ND = N / 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] md;
    logic         dig_valid;
    logic         dig_neg;
    logic         dig_one;
    logic         dig_two;
    logic         dig_ready;
    logic         busy;
    logic [W-1:0] prod;
    logic         prod_valid;
    logic         err;

    int errors = 0;
    int checks = 0;

    // Digit values -2..+2; the value 3 stands for an illegal digit (one = two = 1).
    int           dq[ND];
    logic [W-1:0] last_prod = '0;

    booth_pp_accumulator #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md         (md),
        .dig_valid  (dig_valid),
        .dig_neg    (dig_neg),
        .dig_one    (dig_one),
        .dig_two    (dig_two),
        .dig_ready  (dig_ready),
        .busy       (busy),
        .prod       (prod),
        .prod_valid (prod_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d);
        dig_valid = 1'b1;
        if (d == 3) begin
            dig_neg = $urandom_range(0, 1) == 1;
            dig_one = 1'b1;
            dig_two = 1'b1;
        end else begin
            dig_neg = (d < 0);
            dig_one = (d == 1) || (d == -1);
            dig_two = (d == 2) || (d == -2);
        end
    endtask

    // Reference: product = md * (sum of d_k * 4^k), illegal digits count as 0.
    function automatic logic [W-1:0] model(input logic [N-1:0] mdv);
        int mi;
        int mr;
        mi = $signed(mdv);
        mr = 0;
        for (int k = 0; k < ND; k++) begin
            if (dq[k] != 3) mr = mr + dq[k] * (1 << (2 * k));
        end
        return W'(mi * mr);
    endfunction

    function automatic bit any_illegal();
        bit r;
        r = 1'b0;
        for (int k = 0; k < ND; k++) if (dq[k] == 3) r = 1'b1;
        return r;
    endfunction

    // One full operation; returns sampled in the DONE cycle (prod_valid high).
    task automatic run_op(input logic [N-1:0] mdv, input bit bubbles, input bit spur, input string name);
        logic [W-1:0] exp;
        bit ill;
        int nb;
        exp = model(mdv);
        ill = any_illegal();
        start = 1'b1;
        md = mdv;
        dig_valid = 1'b0;
        tick();
        start = 1'b0;
        md = N'($urandom);
        checks++;
        if (busy !== 1'b1 || dig_ready !== 1'b1)
            $display("FAIL %s start_busy: busy=%b dig_ready=%b expected 1 1", name, busy, dig_ready);
        else if (err !== 1'b0 || prod !== last_prod) begin
            errors++;
            $display("FAIL %s start_state: err=%b prod=%h expected err=0 prod=%h", name, err, prod, last_prod);
        end
        if (busy !== 1'b1 || dig_ready !== 1'b1) errors++;
        for (int k = 0; k < ND; k++) begin
            if (bubbles) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    dig_valid = 1'b0;
                    tick();
                    checks++;
                    if (prod_valid !== 1'b0 || busy !== 1'b1 || prod !== last_prod) begin
                        errors++;
                        $display("FAIL %s bubble: prod_valid=%b busy=%b prod=%h expected 0 1 %h",
                                 name, prod_valid, busy, prod, last_prod);
                    end
                end
            end
            drive_digit(dq[k]);
            if (spur && k == 1) begin
                start = 1'b1;
                md = 8'h55;
            end
            tick();
            start = 1'b0;
            if (k < ND - 1) begin
                checks++;
                if (prod_valid !== 1'b0 || busy !== 1'b1 || prod !== last_prod) begin
                    errors++;
                    $display("FAIL %s mid_digit%0d: prod_valid=%b busy=%b prod=%h expected 0 1 %h",
                             name, k, prod_valid, busy, prod, last_prod);
                end
            end
        end
        dig_valid = 1'b0;
        checks++;
        if (prod_valid !== 1'b1 || prod !== exp) begin
            errors++;
            $display("FAIL %s result: prod_valid=%b prod=%h expected 1 %h", name, prod_valid, prod, exp);
        end
        checks++;
        if (busy !== 1'b0 || dig_ready !== 1'b0 || err !== ill) begin
            errors++;
            $display("FAIL %s done_flags: busy=%b dig_ready=%b err=%b expected 0 0 %b",
                     name, busy, dig_ready, err, ill);
        end
        last_prod = exp;
    endtask

    task automatic idle_check(input string name);
        tick();
        checks++;
        if (prod_valid !== 1'b0 || prod !== last_prod || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: prod_valid=%b prod=%h busy=%b expected 0 %h 0",
                     name, prod_valid, prod, busy, last_prod);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md = '0;
        dig_valid = 1'b0;
        dig_neg = 1'b0;
        dig_one = 1'b0;
        dig_two = 1'b0;
        #12;
        checks++;
        if ({dig_ready, busy, prod, prod_valid, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h expected 0", {dig_ready, busy, prod, prod_valid, err});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_check("post_reset");
    endtask

    task automatic test_vectors();
        dq = '{-1, 1, 0, 0};
        run_op(8'd7, 1'b0, 1'b0, "md7_mr3");
        idle_check("md7_mr3");
        dq = '{-1, 0, 0, 2};
        run_op(8'd127, 1'b0, 1'b0, "md127_mr127");
        idle_check("md127_mr127");
        dq = '{0, 0, 0, -2};
        run_op(8'h80, 1'b0, 1'b0, "mdm128_mrm128");
        idle_check("mdm128_mrm128");
    endtask

    task automatic test_bubbles_spurious();
        dq = '{1, -1, 1, 0};
        run_op(8'd5, 1'b1, 1'b1, "bubbles_spur");
        idle_check("bubbles_spur");
    endtask

    task automatic test_illegal();
        dq = '{1, 3, 0, 0};
        run_op(8'd3, 1'b0, 1'b0, "illegal");
        idle_check("illegal");
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_back_to_back();
        dq = '{2, -2, 1, -1};
        run_op(8'd9, 1'b0, 1'b0, "b2b_a");
        dq = '{-2, 0, 1, 1};
        run_op(8'hF3, 1'b0, 1'b0, "b2b_b");
        dq = '{1, 1, 1, 1};
        run_op(8'd1, 1'b0, 1'b0, "b2b_c");
        idle_check("b2b_c");
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        md = 8'd9;
        tick();
        start = 1'b0;
        drive_digit(1);
        tick();
        drive_digit(2);
        tick();
        dig_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({dig_ready, busy, prod, prod_valid, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs=%h expected 0", {dig_ready, busy, prod, prod_valid, err});
        end
        last_prod = '0;
        tick();
        reset = 1'b0;
        idle_check("reset_mid_idle");
        dq = '{0, 1, 0, 0};
        run_op(8'd6, 1'b0, 1'b0, "after_reset");
        idle_check("after_reset");
    endtask

    task automatic test_random();
        logic [N-1:0] mdv;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < ND; k++) begin
                if ($urandom_range(0, 9) == 0) dq[k] = 3;
                else dq[k] = int'($urandom_range(0, 4)) - 2;
            end
            mdv = N'($urandom);
            run_op(mdv, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, "random");
            if ($urandom_range(0, 1) == 1) idle_check("random");
        end
        idle_check("random_end");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_bubbles_spurious();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
